// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 loader.
// RS232_PARITY_EN adds the PARITY state to the FSM encoding.
package rs232_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

`ifdef RS232_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WRITE, ST_RECOVER
   } rx_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WRITE, ST_RECOVER
   } rx_state_t;
`endif

   // Rounded clocks-per-oversample-tick, never below 1.
   function automatic int baud_div(input int clk_freq, input int baud);
      int div;
      div = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held at
// zero while iClear is high.
module rs232_baud_tick #(
   parameter int DIV = 4
) (
   input  logic iClock,
   input  logic iReset,
   input  logic iClear,
   output logic oTick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] count;

   assign oTick = (count == CNT_W'(DIV - 1));

   always_ff @(posedge iClock) begin
      if (iReset || iClear || oTick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rs232_loader.sv
// RS-232 receiver that writes each received byte to sequential memory
// addresses. Define RS232_PARITY_EN for 8E1 framing (default 8N1).
module rs232_loader
   import rs232_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200,
   parameter int ADDR_W   = 16
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iUart_Rxd,
   output logic [7:0]        oData,
   output logic [ADDR_W-1:0] oAddress,
   output logic              oWrite,
   output logic              oLoadDone,
   output logic              oFrameError,
   output logic              oBusy
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD);

   rx_state_t  state;
   logic       rxd_meta, rxd_sync, rxd_prev;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       bad_frame;
   logic       tick;
   logic       tick_clear;
   logic       tick_last;

   assign tick_clear = (state == ST_IDLE);
   assign tick_last  = tick && (tick_cnt == 4'(OVERSAMPLE - 1));

   rs232_baud_tick #(.DIV(DIV)) u_baud_tick (
      .iClock (iClock),
      .iReset (iReset),
      .iClear (tick_clear),
      .oTick  (tick)
   );

   // NOTE: every register here uses <= so all branches see pre-edge values.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         // NOTE: synchroniser flops reset to the idle-high line level so no
         // false start edge appears when reset releases.
         rxd_meta    <= 1'b1;
         rxd_sync    <= 1'b1;
         rxd_prev    <= 1'b1;
         state       <= ST_IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         bad_frame   <= 1'b0;
         oData       <= '0;
         oAddress    <= '0;
         oWrite      <= 1'b0;
         oLoadDone   <= 1'b0;
         oFrameError <= 1'b0;
         oBusy       <= 1'b0;
      end else begin
         rxd_meta    <= iUart_Rxd;
         rxd_sync    <= rxd_meta;
         rxd_prev    <= rxd_sync;
         oWrite      <= 1'b0;
         oLoadDone   <= 1'b0;
         oFrameError <= 1'b0;
         if (tick) tick_cnt <= tick_cnt + 4'd1;

         unique case (state)
            ST_IDLE: begin
               if (rxd_prev && !rxd_sync) begin
                  state     <= ST_START;
                  tick_cnt  <= '0;
                  bit_cnt   <= '0;
                  bad_frame <= 1'b0;
                  oBusy     <= 1'b1;
               end
            end
            ST_START: begin
               // Re-align the tick count to mid-bit so later samples land centred.
               if (tick && tick_cnt == 4'(MID_SAMPLE - 1)) begin
                  tick_cnt <= '0;
                  if (!rxd_sync) begin
                     state <= ST_DATA;
                  end else begin
                     state <= ST_IDLE;
                     oBusy <= 1'b0;
                  end
               end
            end
            ST_DATA: begin
               if (tick_last) begin
                  shift   <= {rxd_sync, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
`ifdef RS232_PARITY_EN
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
`else
                  if (bit_cnt == 3'd7) state <= ST_STOP;
`endif
               end
            end
`ifdef RS232_PARITY_EN
            ST_PARITY: begin
               if (tick_last) begin
                  bad_frame <= ^{shift, rxd_sync};
                  state     <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (tick_last) begin
                  if (rxd_sync && !bad_frame) begin
                     oData  <= shift;
                     oWrite <= 1'b1;
                     state  <= ST_WRITE;
                  end else begin
                     oFrameError <= 1'b1;
                     state       <= ST_RECOVER;
                  end
               end
            end
            ST_WRITE: begin
               oAddress  <= oAddress + ADDR_W'(1);
               oLoadDone <= &oAddress;
               oBusy     <= 1'b0;
               state     <= ST_IDLE;
            end
            ST_RECOVER: begin
               if (rxd_sync) begin
                  oBusy <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               oBusy <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_loader.sv
// Directed testbench for rs232_loader at 64 clocks per bit, ADDR_W=4.
module tb_rs232_loader;

   localparam int CLK_FREQ = 7_372_800;
   localparam int BAUD     = 115200;
   localparam int ADDR_W   = 4;
   localparam int BIT_CLKS = 64;

   logic              iClock = 1'b0;
   logic              iReset = 1'b1;
   logic              iUart_Rxd = 1'b1;
   logic [7:0]        oData;
   logic [ADDR_W-1:0] oAddress;
   logic              oWrite;
   logic              oLoadDone;
   logic              oFrameError;
   logic              oBusy;

   rs232_loader #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .ADDR_W   (ADDR_W)
   ) dut (
      .iClock      (iClock),
      .iReset      (iReset),
      .iUart_Rxd   (iUart_Rxd),
      .oData       (oData),
      .oAddress    (oAddress),
      .oWrite      (oWrite),
      .oLoadDone   (oLoadDone),
      .oFrameError (oFrameError),
      .oBusy       (oBusy)
   );

   always #5 iClock = ~iClock;

   int cyc = 0;
   always @(posedge iClock) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Strobe log collected away from the active edge.
   logic [7:0]        wr_data[$];
   logic [ADDR_W-1:0] wr_addr[$];
   int last_wr_cyc = -1;
   int done_cyc = -1;
   int n_err = 0;
   int n_done = 0;

   always @(negedge iClock) begin
      if (!iReset) begin
         if (oWrite) begin
            wr_data.push_back(oData);
            wr_addr.push_back(oAddress);
            last_wr_cyc = cyc;
         end
         if (oFrameError) n_err++;
         if (oLoadDone) begin
            n_done++;
            done_cyc = cyc;
         end
         if (oWrite || oLoadDone || oFrameError)
            check("strobe_exclusive", 32'(oWrite) + 32'(oLoadDone) + 32'(oFrameError), 1);
      end
   end

   task automatic clear_log();
      wr_data.delete();
      wr_addr.delete();
      last_wr_cyc = -1;
      done_cyc = -1;
      n_err = 0;
      n_done = 0;
   endtask

   task automatic do_reset();
      iReset = 1'b1;
      iUart_Rxd = 1'b1;
      repeat (3) @(posedge iClock);
      iReset = 1'b0;
      repeat (3) @(posedge iClock);
      clear_log();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_write"}, 32'(oWrite), 0);
      check({tag, "_data"}, 32'(oData), 0);
      check({tag, "_addr"}, 32'(oAddress), 0);
      check({tag, "_done"}, 32'(oLoadDone), 0);
      check({tag, "_ferr"}, 32'(oFrameError), 0);
      check({tag, "_busy"}, 32'(oBusy), 0);
   endtask

   task automatic idle(input int n);
      iUart_Rxd = 1'b1;
      repeat (n) @(posedge iClock);
   endtask

   task automatic send_bit(input logic v);
      iUart_Rxd = v;
      repeat (BIT_CLKS) @(posedge iClock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef RS232_PARITY_EN
      send_bit(^b);
`endif
      send_bit(stop_v);
   endtask

`ifdef RS232_PARITY_EN
   task automatic send_byte_bad_parity(input logic [7:0] b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b));
      send_bit(1'b1);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [7:0] b2b_exp[3] = '{8'h00, 8'hFF, 8'h3C};
   int waited;

   initial begin
      // Reset values.
      iReset = 1'b1;
      iUart_Rxd = 1'b1;
      repeat (3) @(posedge iClock);
      @(negedge iClock);
      check_all_zero("reset");
      iReset = 1'b0;
      repeat (3) @(posedge iClock);
      clear_log();

      // Single byte.
      send_byte(8'hA5);
      idle(10);
      @(negedge iClock);
      check("a5_count", wr_data.size(), 1);
      if (wr_data.size() > 0) begin
         check("a5_data", wr_data[0], 8'hA5);
         check("a5_addr", wr_addr[0], 0);
      end
      check("a5_next_addr", oAddress, 1);
      check("a5_err", n_err, 0);

      // Three back-to-back frames with zero idle between them.
      do_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h3C);
      idle(10);
      @(negedge iClock);
      check("b2b_count", wr_data.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (wr_data.size() > i) begin
            check($sformatf("b2b_data%0d", i), wr_data[i], b2b_exp[i]);
            check($sformatf("b2b_addr%0d", i), wr_addr[i], i);
         end
      end

      // Bad stop bit, line held low, then recovery and a good frame.
      clear_log();
      send_byte(8'h55, 1'b0);
      iUart_Rxd = 1'b0;
      repeat (100) @(posedge iClock);
      @(negedge iClock);
      check("ferr_count", n_err, 1);
      check("ferr_no_write", wr_data.size(), 0);
      check("ferr_recover_busy", 32'(oBusy), 1);
      check("ferr_addr_held", oAddress, 3);
      idle(10);
      @(negedge iClock);
      check("ferr_back_idle", 32'(oBusy), 0);
      send_byte(8'h12);
      idle(10);
      @(negedge iClock);
      check("after_ferr_count", wr_data.size(), 1);
      if (wr_data.size() > 0) begin
         check("after_ferr_data", wr_data[0], 8'h12);
         check("after_ferr_addr", wr_addr[0], 3);
      end

      // 20-clock low glitch on an idle line.
      clear_log();
      idle(5);
      iUart_Rxd = 1'b0;
      repeat (20) @(posedge iClock);
      iUart_Rxd = 1'b1;
      @(negedge iClock);
      check("glitch_seen_busy", 32'(oBusy), 1);
      waited = 20;
      while (oBusy && waited < 80) begin
         @(posedge iClock);
         @(negedge iClock);
         waited++;
      end
      check("glitch_idle_in_time", 32'(waited <= 40), 1);
      idle(100);
      @(negedge iClock);
      check("glitch_no_write", wr_data.size(), 0);
      check("glitch_no_err", n_err, 0);
      check("glitch_addr", oAddress, 4);

      // Reset in the middle of bit 4 of 0x81.
      clear_log();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      iUart_Rxd = 1'b0;
      repeat (32) @(posedge iClock);
      @(negedge iClock);
      check("midreset_busy_before", 32'(oBusy), 1);
      @(posedge iClock);
      iReset = 1'b1;
      iUart_Rxd = 1'b1;
      @(posedge iClock);
      @(negedge iClock);
      check_all_zero("midreset");
      iReset = 1'b0;
      idle(BIT_CLKS * 12);
      @(negedge iClock);
      check("midreset_no_write", wr_data.size(), 0);
      send_byte(8'h7E);
      idle(10);
      @(negedge iClock);
      check("post_reset_count", wr_data.size(), 1);
      if (wr_data.size() > 0) begin
         check("post_reset_data", wr_data[0], 8'h7E);
         check("post_reset_addr", wr_addr[0], 0);
      end

      // Fill the whole 16-entry address space.
      do_reset();
      for (int i = 0; i < 16; i++) send_byte(8'(i * 13 + 1));
      idle(10);
      @(negedge iClock);
      check("fill_count", wr_data.size(), 16);
      if (wr_data.size() == 16) begin
         check("fill_last_addr", wr_addr[15], 15);
         check("fill_last_data", wr_data[15], 8'hC4);
         check("fill_first_data", wr_data[0], 8'h01);
      end
      check("fill_done_count", n_done, 1);
      check("fill_done_timing", done_cyc, last_wr_cyc + 1);
      check("fill_addr_wrapped", oAddress, 0);

`ifdef RS232_PARITY_EN
      // Wrong parity bit.
      clear_log();
      send_byte_bad_parity(8'h3C);
      idle(10);
      @(negedge iClock);
      check("parity_err", n_err, 1);
      check("parity_no_write", wr_data.size(), 0);
      check("parity_addr_held", oAddress, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs232_loader.md
# rs232_loader

Receive-side counterpart of the capture/dump path. Deserialises 8N1 RS-232 frames from the UART RX pin and writes each received byte into the sample memory at a sequentially incrementing address. Pulses a completion strobe once the full address space has been filled. Sits between the board RX pin and the memory write port, so a host can preload memory that is later replayed or dumped.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- ADDR_W, 16: memory address width; the load length is 2^ADDR_W bytes.

- iClock  in  1  system clock, rising edge.
- iReset  in  1  synchronous, active-high reset.
- iUart_Rxd  in  1  asynchronous serial input, idle high.
- oData  out  8  received byte, valid while oWrite is high.
- oAddress  out  ADDR_W  write address for oData.
- oWrite  out  1  one-cycle memory write strobe.
- oLoadDone  out  1  one-cycle pulse after the write to address 2^ADDR_W-1.
- oFrameError  out  1  one-cycle pulse on a bad stop bit (or bad parity when enabled).
- oBusy  out  1  high from start-bit detection until the frame is finished.

## Operation
- Reset values: all outputs 0; oAddress 0; FSM in IDLE; synchroniser flops 1.
- iUart_Rxd passes through a 2-flop synchroniser before any use.
- Tick generator: one-cycle tick every DIV = round(CLK_FREQ/(BAUD*16)) clocks. The tick counter runs free while the FSM is not IDLE and is cleared on leaving IDLE.
- FSM states: IDLE, START, DATA, PARITY (only when RS232_PARITY_EN is defined), STOP, WRITE, RECOVER.
  - IDLE: a synchronised 1→0 transition moves to START and clears the tick and bit counters.
  - START: after 8 ticks (mid start bit), sample the line. Low → DATA. High → IDLE (glitch rejected, no error).
  - DATA: sample every 16 ticks, LSB first, into the shift register. After 8 bits → PARITY or STOP.
  - PARITY: sample 16 ticks later. Even parity over data plus parity bit must be 0; a mismatch sets an error flag. → STOP.
  - STOP: sample 16 ticks later.
    - High with no error flag → WRITE.
    - Otherwise pulse oFrameError, discard the byte, → RECOVER.
  - WRITE: one cycle. oWrite=1, oData=shift register, oAddress=current address. → IDLE.
  - RECOVER: wait until the synchronised line is high → IDLE.
- Address: increments in the cycle after oWrite, 2^ADDR_W wraps to 0. When a write hits the last address, oLoadDone pulses in the cycle after oWrite, coincident with the wrap to 0.
- oBusy is high in every state except IDLE.
- Reset mid-frame: returns to IDLE immediately and zeroes the address. Any partial byte is lost and no strobe is emitted.
- Error pulses do not advance the address.

## Timing
- Synchroniser latency: 2 clocks.
- Stop-bit sample to oWrite: 1 clock.
- Start edge to oWrite: about 9.5 bit periods (10.5 with parity) plus 3 clocks.
- oWrite, oLoadDone and oFrameError are exactly one clock wide and never overlap within a cycle.
- Back-to-back frames are accepted: WRITE returns to IDLE before the next start edge can be due (the start edge falls at least half a bit after the stop-bit sample).

## Configuration
- RS232_PARITY_EN defined: frame is 8E1; PARITY state is present; parity mismatch is reported via oFrameError.
- RS232_PARITY_EN undefined: frame is 8N1; PARITY state and its logic are absent.

## Structure
- Shared package rs232_pkg:
  - FSM state typedef.
  - OVERSAMPLE=16 and MID_SAMPLE=8 constants.
  - Divider computation function.
- Sub-module rs232_baud_tick: divider counter with synchronous clear input and a tick output.
- The top level holds the synchroniser, FSM, shift register and address counter.

## Test plan
Sims use CLK_FREQ=7_372_800 and BAUD=115200, giving DIV=4 and 64 clocks per bit.
- Send 0xA5 → oWrite once, oData=0xA5, oAddress=0, then oAddress=1; no error.
- Send 0x00, 0xFF, 0x3C back-to-back with zero idle → three writes at addresses 0, 1, 2 with correct data.
- Frame 0x55 with stop bit driven low → oFrameError pulse, no oWrite, address unchanged. The FSM stays in RECOVER until the line returns high; a following 0x12 is written at the same address.
- Low glitch of 20 clocks on an idle line → no oWrite, no oFrameError; FSM back in IDLE within 33 clocks.
- ADDR_W=4, send 16 bytes → oLoadDone pulses once, one clock after the 16th oWrite; oAddress reads 0.
- Assert iReset during bit 4 of a frame → all outputs 0 next clock; a subsequent clean 0x7E is written at address 0. With RS232_PARITY_EN defined, a wrong parity bit gives oFrameError.
